// File: rtl/decode_in_capture_buffer.sv
// Capture buffer for the LC3 decode_in interface: timestamps enabled
// (instr, npc) samples into a first-word-fall-through FIFO with valid/ready drain.
module decode_in_capture_buffer #(
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 8,
  parameter int TS_W          = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int DEDUP         = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable_decode,
  input  logic [DATA_W-1:0]       npc_in,
  input  logic [DATA_W-1:0]       instr_dout,
  input  logic                    capture_en,
  input  logic                    clear,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_instr,
  output logic [DATA_W-1:0]       out_npc,
  output logic [TS_W-1:0]         out_ts,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int EW = PW + TS_W;

  typedef enum logic [1:0] {
    WAIT_RST,
    IDLE,
    RUN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SW-1:0]     r_settle;
  logic [TS_W-1:0]   r_ts;
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic [15:0]       r_drops;
  logic              r_hist_v;
  logic [PW-1:0]     r_hist;
  logic [EW-1:0]     r_mem [DEPTH];

  logic              w_settle_done;
  logic [PW-1:0]     w_pair;
  logic              w_sample;
  logic              w_dup;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [EW-1:0]     w_head;

  assign w_settle_done = (r_state == WAIT_RST) &&
                         (r_settle == SW'(SETTLE_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      WAIT_RST: if (w_settle_done) w_next = capture_en ? RUN : IDLE;
      IDLE:     if (capture_en) w_next = RUN;
      RUN:      if (!capture_en) w_next = IDLE;
      default:  w_next = WAIT_RST;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= WAIT_RST;
      r_settle <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WAIT_RST && !w_settle_done)
        r_settle <= r_settle + 1'b1;
    end
  end

  // Timestamp starts on the settle-exit edge so the first capturable sample reads 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_ts <= '0;
    else if (r_state != WAIT_RST || w_settle_done)
      r_ts <= r_ts + 1'b1;
  end

  assign w_pair   = {instr_dout, npc_in};
  assign w_sample = (r_state == RUN) && enable_decode;
  assign w_dup    = (DEDUP != 0) && r_hist_v && (w_pair == r_hist);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop    = !clear && out_valid && out_ready;
  assign w_push   = !clear && w_sample && !w_dup && (!w_full || w_pop);
  assign w_drop   = !clear && w_sample && !w_dup && w_full && !w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_drops  <= '0;
      r_hist_v <= 1'b0;
      r_hist   <= '0;
    end else if (clear) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_drops  <= '0;
      r_hist_v <= 1'b0;
      r_hist   <= '0;
    end else begin
      if (w_push) begin
        r_wr     <= r_wr + 1'b1;
        r_hist   <= w_pair;
        r_hist_v <= 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drops != 16'hFFFF)
          r_drops <= r_drops + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wr] <= {w_pair, r_ts};
  end

  // Head is masked so stale storage never shows while empty.
  assign out_valid = (r_count != '0);
  assign w_head    = out_valid ? r_mem[r_rd] : '0;
  assign out_instr = w_head[EW-1 -: DATA_W];
  assign out_npc   = w_head[TS_W +: DATA_W];
  assign out_ts    = w_head[TS_W-1:0];
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign drop_count = r_drops;

endmodule

// File: tb/tb_decode_in_capture_buffer.sv
// Bench for decode_in_capture_buffer: DEDUP=0 and DEDUP=1 instances
// driven in parallel and checked against a queue-based reference model.
module tb_decode_in_capture_buffer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] n;
    logic [15:0] t;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b0;
  logic        capture_en = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] npc_in = '0;
  logic [15:0] instr_dout = '0;

  logic        vld [2];
  logic [15:0] oi  [2];
  logic [15:0] on  [2];
  logic [15:0] ot  [2];
  logic [3:0]  cnt [2];
  logic        ov  [2];
  logic [15:0] odc [2];

  int checks = 0;
  int errors = 0;

  ent_t        mq [2][$];
  bit          mov [2];
  int          mdc [2];
  bit          mhv [2];
  logic [31:0] mhist [2];
  int          mstate;
  int          mwait;
  logic [15:0] mts;

  always #5 clk = ~clk;

  decode_in_capture_buffer #(
    .DATA_W(16), .DEPTH(DEPTH), .TS_W(16),
    .SETTLE_CYCLES(1), .DEDUP(0)
  ) u_dut0 (
    .clock(clk), .reset(reset), .enable_decode(enable_decode),
    .npc_in(npc_in), .instr_dout(instr_dout),
    .capture_en(capture_en), .clear(clear), .out_ready(out_ready),
    .out_valid(vld[0]), .out_instr(oi[0]), .out_npc(on[0]),
    .out_ts(ot[0]), .count(cnt[0]), .overflow(ov[0]),
    .drop_count(odc[0])
  );

  decode_in_capture_buffer #(
    .DATA_W(16), .DEPTH(DEPTH), .TS_W(16),
    .SETTLE_CYCLES(1), .DEDUP(1)
  ) u_dut1 (
    .clock(clk), .reset(reset), .enable_decode(enable_decode),
    .npc_in(npc_in), .instr_dout(instr_dout),
    .capture_en(capture_en), .clear(clear), .out_ready(out_ready),
    .out_valid(vld[1]), .out_instr(oi[1]), .out_npc(on[1]),
    .out_ts(ot[1]), .count(cnt[1]), .overflow(ov[1]),
    .drop_count(odc[1])
  );

  // mstate: 0 = settling after reset, 1 = idle, 2 = capturing
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mov[d] = 0;
      mdc[d] = 0;
      mhv[d] = 0;
      mhist[d] = '0;
    end
    mstate = 0;
    mwait = 0;
    mts = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit samp;
        bit dup;
        if (clear) begin
          mq[d].delete();
          mov[d] = 0;
          mdc[d] = 0;
          mhv[d] = 0;
        end else begin
          if (mq[d].size() > 0 && out_ready)
            void'(mq[d].pop_front());
          samp = (mstate == 2) && enable_decode;
          dup = (d == 1) && mhv[d] &&
                ({instr_dout, npc_in} == mhist[d]);
          if (samp && !dup) begin
            if (mq[d].size() < DEPTH) begin
              mq[d].push_back('{instr_dout, npc_in, mts});
              mhv[d] = 1;
              mhist[d] = {instr_dout, npc_in};
            end else begin
              mov[d] = 1;
              if (mdc[d] < 65535) mdc[d]++;
            end
          end
        end
      end
      if (mstate == 0) begin
        mwait++;
        if (mwait >= 1) begin
          mstate = capture_en ? 2 : 1;
          mts++;
        end
      end else begin
        mstate = capture_en ? 2 : 1;
        mts++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vld[d], cnt[d], ov[d], odc[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outs[%0d]: got v=%b c=%0d o=%b dc=%0d want all 0",
                 d, vld[d], cnt[d], ov[d], odc[d]);
      end
      checks++;
      if ({oi[d], on[d], ot[d]} !== '0) begin
        errors++;
        $display("FAIL reset_head[%0d]: got %h/%h/%h want 0",
                 d, oi[d], on[d], ot[d]);
      end
    end
    reset = 1'b0;
    capture_en = 1'b1;
    enable_decode = 1'b1;
    instr_dout = 16'hAAAA;
    npc_in = 16'h1111;
    step();
    checks++;
    if (cnt[0] !== 4'd0) begin
      errors++;
      $display("FAIL settle_nocap: got count %0d want 0", cnt[0]);
    end
    instr_dout = 16'hBBBB;
    npc_in = 16'h2222;
    step();
    enable_decode = 1'b0;
    checks++;
    if (vld[0] !== 1'b1 || oi[0] !== 16'hBBBB || ot[0] !== 16'd1) begin
      errors++;
      $display("FAIL first_cap: got v=%b i=%h ts=%0d want v=1 i=bbbb ts=1",
               vld[0], oi[0], ot[0]);
    end
  endtask

  task automatic test_fifo_order();
    logic [15:0] ins [3];
    logic [15:0] pcs [3];
    logic [15:0] ts0;
    ins = '{16'h1234, 16'h5678, 16'h9ABC};
    pcs = '{16'h3000, 16'h3001, 16'h3002};
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b0;
    enable_decode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr_dout = ins[k];
      npc_in = pcs[k];
      step();
    end
    enable_decode = 1'b0;
    checks++;
    if (cnt[0] !== 4'd3 || vld[0] !== 1'b1) begin
      errors++;
      $display("FAIL order_fill: got count %0d valid %b want 3 1",
               cnt[0], vld[0]);
    end
    ts0 = ot[0];
    step();
    step();
    checks++;
    if (oi[0] !== 16'h1234 || on[0] !== 16'h3000 || ot[0] !== ts0 ||
        ot[0] !== mq[0][0].t) begin
      errors++;
      $display("FAIL order_hold: got %h/%h ts %0d want 1234/3000 ts %0d",
               oi[0], on[0], ot[0], mq[0][0].t);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oi[0] !== ins[k] || on[0] !== pcs[k] || vld[0] !== 1'b1) begin
        errors++;
        $display("FAIL order_pop%0d: got v=%b %h/%h want 1 %h/%h",
                 k, vld[0], oi[0], on[0], ins[k], pcs[k]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (cnt[0] !== 4'd0 || vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL order_empty: got count %0d valid %b want 0 0",
               cnt[0], vld[0]);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    enable_decode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      instr_dout = 16'h0100 + 16'(k);
      npc_in = 16'h4000 + 16'(k);
      step();
    end
    enable_decode = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cnt[d] !== 4'd8 || ov[d] !== 1'b1 || odc[d] !== 16'd2) begin
        errors++;
        $display("FAIL ovf[%0d]: got c=%0d o=%b dc=%0d want 8 1 2",
                 d, cnt[d], ov[d], odc[d]);
      end
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (cnt[0] !== 4'd0 || ov[0] !== 1'b0 || odc[0] !== 16'd0 ||
        vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got c=%0d o=%b dc=%0d v=%b want 0",
               cnt[0], ov[0], odc[0], vld[0]);
    end
  endtask

  task automatic test_full_pop();
    enable_decode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      instr_dout = 16'h2000 + 16'(k);
      npc_in = 16'h5000 + 16'(k);
      step();
    end
    instr_dout = 16'h2FFF;
    out_ready = 1'b1;
    step();
    enable_decode = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (cnt[0] !== 4'd8 || odc[0] !== 16'd0 || ov[0] !== 1'b0 ||
        oi[0] !== 16'h2001) begin
      errors++;
      $display("FAIL full_pop: got c=%0d dc=%0d o=%b head %h want 8 0 0 2001",
               cnt[0], odc[0], ov[0], oi[0]);
    end
  endtask

  task automatic test_dedup();
    clear = 1'b1;
    step();
    clear = 1'b0;
    enable_decode = 1'b1;
    instr_dout = 16'h1234;
    npc_in = 16'h3000;
    for (int k = 0; k < 4; k++) step();
    instr_dout = 16'h1235;
    npc_in = 16'h3001;
    step();
    enable_decode = 1'b0;
    checks++;
    if (cnt[1] !== 4'd2 || ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL dedup: got count %0d ovf %b want 2 0", cnt[1], ov[1]);
    end
    checks++;
    if (cnt[0] !== 4'd5) begin
      errors++;
      $display("FAIL nodedup: got count %0d want 5", cnt[0]);
    end
  endtask

  task automatic test_random();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 24) == 0) capture_en = ~capture_en;
      enable_decode = ($urandom_range(0, 2) != 0);
      out_ready = ((c / 80) % 2 == 1) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 59) == 0);
      instr_dout = 16'h1000 + 16'($urandom_range(0, 2));
      npc_in = 16'h3000 + 16'($urandom_range(0, 1));
      step();
      for (int d = 0; d < 2; d++) begin
        ent_t h;
        h = (mq[d].size() > 0) ? mq[d][0] : '0;
        checks++;
        if (vld[d] !== (mq[d].size() > 0) || cnt[d] !== 4'(mq[d].size())) begin
          errors++;
          $display("FAIL rnd_occ[%0d] cyc %0d: got v=%b c=%0d want c=%0d",
                   d, c, vld[d], cnt[d], mq[d].size());
        end
        checks++;
        if (ov[d] !== mov[d] || odc[d] !== 16'(mdc[d])) begin
          errors++;
          $display("FAIL rnd_ovf[%0d] cyc %0d: got o=%b dc=%0d want %b %0d",
                   d, c, ov[d], odc[d], mov[d], mdc[d]);
        end
        checks++;
        if ({oi[d], on[d], ot[d]} !== h) begin
          errors++;
          $display("FAIL rnd_head[%0d] cyc %0d: got %h/%h/%h want %h/%h/%h",
                   d, c, oi[d], on[d], ot[d], h.i, h.n, h.t);
        end
      end
    end
    clear = 1'b0;
    capture_en = 1'b1;
    enable_decode = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b0;
    enable_decode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instr_dout = 16'h7000 + 16'(k);
      npc_in = 16'h6000 + 16'(k);
      step();
    end
    enable_decode = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (cnt[0] !== 4'd5) begin
      errors++;
      $display("FAIL arst_pre: got count %0d want 5", cnt[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (vld[d] !== 1'b0 || cnt[d] !== 4'd0) begin
        errors++;
        $display("FAIL arst_now[%0d]: got v=%b c=%0d want 0 0",
                 d, vld[d], cnt[d]);
      end
    end
    @(negedge clk);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (vld[0] !== 1'b0 || cnt[0] !== 4'd0 || oi[0] !== 16'h0) begin
      errors++;
      $display("FAIL arst_stale: got v=%b c=%0d i=%h want 0 0 0",
               vld[0], cnt[0], oi[0]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fifo_order();
    test_overflow();
    test_full_pop();
    test_dedup();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
